// File: rtl/iq_demod_pkg.sv
// Shared widths, output word type and accumulator slicing helper for the I/Q demodulator.
package iq_demod_pkg;

    localparam int DEF_ADC_WIDTH      = 14;
    localparam int DEF_AMPLITUDE_BITS = 14;
    localparam int DEF_ACC_WIDTH      = 48;
    localparam int DEF_DECIM_WIDTH    = 16;
    localparam int DEF_OUT_WIDTH      = 32;

    localparam int MAX_ACC_WIDTH = 128;
    localparam int MAX_OUT_WIDTH = 64;

    typedef struct packed {
        logic signed [DEF_OUT_WIDTH-1:0] q;
        logic signed [DEF_OUT_WIDTH-1:0] i;
    } iq_word_t;

    // Top out_w bits of an acc_w-bit accumulator: a plain arithmetic floor, no rounding.
    function automatic logic [MAX_OUT_WIDTH-1:0] top_slice(
        input logic [MAX_ACC_WIDTH-1:0] acc,
        input int                       acc_w,
        input int                       out_w
    );
        return MAX_OUT_WIDTH'(acc >> (acc_w - out_w));
    endfunction

endpackage

// File: rtl/iq_demod_accum_mac_dump.sv
// One channel of signed accumulate-and-dump; result is the block sum including the current product.
module mac_dump
    import iq_demod_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_ADC_WIDTH + DEF_AMPLITUDE_BITS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [PROD_WIDTH-1:0] product_i,
    input  logic                        p_valid_i,
    input  logic                        last_i,
    output logic signed [ACC_WIDTH-1:0]  result_o,
    output logic                        dump_o
);

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum;

    assign sum = acc_q + {{(ACC_WIDTH-PROD_WIDTH){product_i[PROD_WIDTH-1]}}, product_i};

    // NOTE: default assignment first so every path drives acc_d and no latch is inferred.
    always_comb begin
        acc_d = acc_q;
        if (p_valid_i) begin
            acc_d = last_i ? '0 : sum;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result_o = sum;
    assign dump_o   = p_valid_i & last_i;

endmodule

// File: rtl/iq_demod_accum.sv
// Mixes ADC samples with NCO sine/cosine, integrates over N samples and emits {Q,I} on AXI4-Stream.
module iq_demod_accum
    import iq_demod_pkg::*;
#(
    parameter int ADC_WIDTH      = DEF_ADC_WIDTH,
    parameter int AMPLITUDE_BITS = DEF_AMPLITUDE_BITS,
    parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
    parameter int DECIM_WIDTH    = DEF_DECIM_WIDTH,
    parameter int OUT_WIDTH      = DEF_OUT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [ADC_WIDTH-1:0]      adc_data,
    input  logic                             adc_valid,
    input  logic signed [AMPLITUDE_BITS-1:0] sine_wave,
    input  logic signed [AMPLITUDE_BITS-1:0] cos_wave,
    input  logic [DECIM_WIDTH-1:0]           decim,
    input  logic                             clear_overflow,
    output logic [2*OUT_WIDTH-1:0]           m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             overflow
);

    localparam int PROD_WIDTH = ADC_WIDTH + AMPLITUDE_BITS;

    logic signed [PROD_WIDTH-1:0] mix_i_q, mix_q_q;
    logic                         p_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mix_i_q   <= '0;
            mix_q_q   <= '0;
            p_valid_q <= 1'b0;
        end else begin
            p_valid_q <= adc_valid;
            if (adc_valid) begin
                mix_i_q <= PROD_WIDTH'(adc_data) * PROD_WIDTH'(cos_wave);
                mix_q_q <= PROD_WIDTH'(adc_data) * PROD_WIDTH'(sine_wave);
            end
        end
    end

    logic [DECIM_WIDTH-1:0] cnt_q, cnt_d, n_q, n_d, n_eff;
    logic                   last;

    // At the start of a block the live decim value governs, so a new N takes effect on block boundaries only.
    always_comb begin
        n_eff = n_q;
        if (cnt_q == '0) begin
            n_eff = (decim == '0) ? DECIM_WIDTH'(1) : decim;
        end
        last  = (cnt_q == n_eff - DECIM_WIDTH'(1));
        n_d   = n_q;
        cnt_d = cnt_q;
        if (p_valid_q) begin
            if (cnt_q == '0) begin
                n_d = n_eff;
            end
            cnt_d = last ? '0 : cnt_q + DECIM_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            n_q   <= DECIM_WIDTH'(1);
        end else begin
            cnt_q <= cnt_d;
            n_q   <= n_d;
        end
    end

    logic signed [ACC_WIDTH-1:0] i_res, q_res;
    logic                        i_dump, q_dump, dump;

    mac_dump #(.PROD_WIDTH(PROD_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac_i (
        .clk       (clk),
        .rst       (rst),
        .product_i (mix_i_q),
        .p_valid_i (p_valid_q),
        .last_i    (last),
        .result_o  (i_res),
        .dump_o    (i_dump)
    );

    mac_dump #(.PROD_WIDTH(PROD_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac_q (
        .clk       (clk),
        .rst       (rst),
        .product_i (mix_q_q),
        .p_valid_i (p_valid_q),
        .last_i    (last),
        .result_o  (q_res),
        .dump_o    (q_dump)
    );

    assign dump = i_dump & q_dump;

    logic [2*OUT_WIDTH-1:0] tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d, ovf_q, ovf_d;
    logic                   load, drop;

    // A dump while the held beat is stalled is discarded; the held beat stays untouched.
    always_comb begin
        load     = dump & (~tvalid_q | m_axis_tready);
        drop     = dump & tvalid_q & ~m_axis_tready;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = {OUT_WIDTH'(top_slice(MAX_ACC_WIDTH'(q_res), ACC_WIDTH, OUT_WIDTH)),
                        OUT_WIDTH'(top_slice(MAX_ACC_WIDTH'(i_res), ACC_WIDTH, OUT_WIDTH))};
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        ovf_d = drop | (ovf_q & ~clear_overflow);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_iq_demod_accum.sv
// Directed scoreboard bench for iq_demod_accum: stimulus pushes expected beats, a monitor pops and compares.
module tb_iq_demod_accum;
    import iq_demod_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [13:0] adc_data;
    logic               adc_valid;
    logic signed [13:0] sine_wave, cos_wave;
    logic [15:0]        decim;
    logic               clear_overflow;
    logic [63:0]        m_axis_tdata;
    logic               m_axis_tvalid, m_axis_tready, overflow;

    iq_demod_accum dut (
        .clk            (clk),
        .rst            (rst),
        .adc_data       (adc_data),
        .adc_valid      (adc_valid),
        .sine_wave      (sine_wave),
        .cos_wave       (cos_wave),
        .decim          (decim),
        .clear_overflow (clear_overflow),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int i;
        int q;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input int q, input int at_cyc);
        exp_t e;
        e.i   = i;
        e.q   = q;
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic send(input int a, input int c, input int s);
        @(posedge clk);
        #1;
        adc_data  = 14'(a);
        cos_wave  = 14'(c);
        sine_wave = 14'(s);
        adc_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            adc_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout_pending", exp_q.size(), 0);
        idle(2);
    endtask

    // Monitor: compares every accepted beat and checks that a stalled beat holds still.
    initial begin : monitor
        logic        prev_stall;
        logic [63:0] prev_data;
        iq_word_t    w;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_tvalid", m_axis_tvalid, 1);
                    check("hold_tdata", m_axis_tdata, prev_data);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    w = m_axis_tdata;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_beat: got I=%0d Q=%0d expected no beat (t=%0t)", w.i, w.q, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_I", w.i, e.i);
                        check("beat_Q", w.q, e.q);
                        if (e.cyc >= 0) check("beat_latency_cycle", cyc, e.cyc);
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst            = 1'b1;
        adc_data       = '0;
        adc_valid      = 1'b0;
        sine_wave      = '0;
        cos_wave       = '0;
        decim          = 16'd4;
        clear_overflow = 1'b0;
        m_axis_tready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", m_axis_tvalid, 0);
        check("reset_tdata", m_axis_tdata, 0);
        check("reset_overflow", overflow, 0);
        rst = 1'b0;
        idle(2);

        // Basic dump: 4 x 1000*8191 = 32,764,000 >> 16 = 499.
        repeat (4) send(1000, 8191, 0);
        push_exp(499, 0, cyc + 2);
        idle(1);
        wait_drain();

        // Negative floor: -32,764,000 >> 16 = -500.
        repeat (4) send(-1000, 8191, 0);
        push_exp(-500, 0, cyc + 2);
        idle(1);
        wait_drain();

        // decim=0 acts as N=1: 8,191,000 >> 16 = 124.
        decim = 16'd0;
        send(1000, 8191, 0);
        push_exp(124, 0, cyc + 2);
        idle(1);
        wait_drain();

        // Backpressure: first result {Q=125, I=249} held, later dumps dropped.
        decim         = 16'd1;
        m_axis_tready = 1'b0;
        send(2000, 8191, 4096);
        push_exp(249, 125, -1);
        send(3000, 8191, 4096);
        send(4000, 8191, 4096);
        check("ovf_after_first_dump", overflow, 0);
        idle(1);
        check("ovf_after_second_dump", overflow, 1);
        idle(3);
        m_axis_tready = 1'b1;
        wait_drain();
        check("ovf_sticky", overflow, 1);
        @(posedge clk);
        #1;
        clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        clear_overflow = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Simultaneous drain and dump: 5 back-to-back beats, each exactly 2 cycles after its sample.
        send(1000, 8191, -8192); push_exp(124, -125, cyc + 2);
        send(2000, 8191, -8192); push_exp(249, -250, cyc + 2);
        send(3000, 8191, -8192); push_exp(374, -375, cyc + 2);
        send(4000, 8191, -8192); push_exp(499, -500, cyc + 2);
        send(5000, 8191, -8192); push_exp(624, -625, cyc + 2);
        idle(1);
        wait_drain();
        check("ovf_after_stream", overflow, 0);

        // Decim change mid-block with stalls: block of 2 then block of 3.
        decim = 16'd2;
        send(800, -8192, 4096);
        idle(1);
        send(1600, -8192, 4096);
        decim = 16'd3;
        push_exp(-300, 150, cyc + 2);
        idle(1);
        send(160, -8192, 4096);
        idle(1);
        send(320, -8192, 4096);
        idle(1);
        send(480, -8192, 4096);
        push_exp(-120, 60, cyc + 2);
        idle(1);
        wait_drain();

        // Reset mid-block: partial sum discarded, next 8 samples give 6,552,800 >> 16 = 99.
        decim = 16'd8;
        repeat (5) send(5000, 8191, 0);
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_tdata", m_axis_tdata, 0);
        check("midrst_overflow", overflow, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) send(100, 8191, 0);
        push_exp(99, 0, cyc + 2);
        idle(1);
        wait_drain();
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/iq_demod_accum.md
# iq_demod_accum

Downstream consumer of the phasemeter NCO. Mixes the incoming ADC sample stream with the NCO sine/cosine outputs, then integrates each product over a runtime-programmable block of N samples (accumulate-and-dump decimation). It presents the decimated I/Q pairs on an AXI4-Stream master for the phase-extraction stage. A sticky flag reports dropped results.

## Interface
Parameters:
- ADC_WIDTH, 14: signed ADC sample width.
- AMPLITUDE_BITS, 14: signed NCO sine/cos width.
- ACC_WIDTH, 48: signed accumulator width per channel. Must be ≥ ADC_WIDTH+AMPLITUDE_BITS+DECIM_WIDTH−1.
- DECIM_WIDTH, 16: width of the decimation count.
- OUT_WIDTH, 32: per-channel output width. AXIS_TDATA_WIDTH = 2·OUT_WIDTH.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- adc_data, in, ADC_WIDTH: signed sample.
- adc_valid, in, 1: sample qualifier.
- sine_wave, in, AMPLITUDE_BITS: signed NCO sine, time-aligned with adc_data.
- cos_wave, in, AMPLITUDE_BITS: signed NCO cosine, time-aligned with adc_data.
- decim, in, DECIM_WIDTH: block length N. 0 is treated as 1.
- clear_overflow, in, 1: synchronous clear of overflow.
- m_axis_tdata, out, 2·OUT_WIDTH: {Q, I}. I occupies the low half.
- m_axis_tvalid, out, 1: output result valid.
- m_axis_tready, in, 1: downstream accept.
- overflow, out, 1: sticky, set when a result is dropped.

## Operation
- Stage 1 (mixer), registered on adc_valid:
  - prod_i = adc_data·cos_wave and prod_q = adc_data·sin_wave.
  - Signed full-precision products, ADC_WIDTH+AMPLITUDE_BITS bits.
  - p_valid is adc_valid delayed by 1 cycle.
- Stage 2 (accumulate), active only on p_valid:
  - Sample counter cnt runs 0..N−1.
  - N is latched from decim when cnt==0 and p_valid. A change to decim mid-block applies from the next block.
  - On p_valid with cnt<N−1: acc += sign-extended product; cnt++.
  - On p_valid with cnt==N−1 (dump):
    - result = acc + product.
    - acc <= 0 and cnt <= 0.
    - The dump is offered to the output register.
  - Gaps in adc_valid stall the pipeline. No state is lost.
- Output truncation: each channel outputs result[ACC_WIDTH−1 -: OUT_WIDTH]. This is an arithmetic floor; there is no rounding or saturation.
- Output register (single entry, AXIS rules):
  - Load on dump when the register is empty (!tvalid) or being drained (tvalid && tready) in the same cycle.
  - On a dump with tvalid && !tready, the new result is discarded, overflow <= 1, and the held tdata is unchanged.
  - tvalid falls on tvalid && tready when no dump loads in that cycle.
  - tdata stays stable while tvalid && !tready.
- overflow is cleared only by clear_overflow or rst. If a set and a clear coincide, the set wins.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, overflow=0.
  - acc=0, cnt=0, p_valid=0, latched N=1.
- Throughput: one sample per cycle. One output per N valid samples.
- Latency: m_axis_tvalid rises 2 clk after the rising edge sampling the N-th adc_valid (1 for the mixer, 1 for the dump into the output register).
- For N=1 with continuous input and tready=1: tvalid stays high and tdata updates every cycle.
- Reset asserted mid-block discards the partial accumulation and any held result. After release, the first block starts at cnt=0.

## Structure
- Shared package iq_demod_pkg holds:
  - Default width localparams.
  - The output-slice helper (top-OUT_WIDTH extraction).
  - A typedef for the {Q,I} output word.
- Sub-module mac_dump: one channel's signed accumulate-and-dump.
  - Inputs: product, p_valid, last.
  - Outputs: result, dump strobe.
  - Instantiated twice, for I and Q.
- The top level owns the mixer registers, the counter with N latch, the output register and the overflow flag.

## Test plan
- Basic dump: adc=1000, cos=8191, sin=0, N=4, tready=1 -> one beat with I=499 (32,764,000>>16), Q=0; tvalid high exactly 1 cycle, 2 cycles after the 4th sample.
- Negative floor: adc=−1000, same settings -> I=−500, Q=0.
- Backpressure and drop: N=1, tready=0 for 3 samples -> first result held stable; overflow=1 after the 2nd dump. Then tready=1 -> first result delivered. clear_overflow -> overflow=0.
- Simultaneous drain and dump: N=1, tready=1 continuously, 5 samples -> 5 consecutive beats, no gaps, overflow stays 0.
- Decim change and stall: N=2, then decim=3 written mid-block, with adc_valid toggling every other cycle -> current block dumps after 2 samples, next after 3, sums correct.
- Reset mid-block: N=8, rst after 5 samples, then 8 samples of adc=100, cos=8191 -> single result I=(8·819,100)>>16=99, unaffected by pre-reset samples.
